multi_pwm_generator: RTL and testbench
======================================

MULTI_PWM_GENERATOR -- requirements
Module: multi_pwm_generator

Interface
REQ-001 Parameter WIDTH, default 8: bit width of counter, duty, step and divider values.
REQ-002 Parameter CHANNELS, default 4: number of independent PWM outputs sharing one time base.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 srst_n  input  1  synchronous, active-low reset.
REQ-005 duty_inc_coarse, duty_inc_fine, duty_dec_coarse, duty_dec_fine  input  CHANNELS each  per-channel duty adjust strobes, one bit per channel.
REQ-006 duty_coarse, duty_fine  input  WIDTH each  adjust step sizes, shared by all channels.
REQ-007 duty_nominal  input  WIDTH  duty loaded into every channel at reset.
REQ-008 div_value  input  WIDTH  period control, in clk cycles.
REQ-009 center_mode  input  1  0 = edge-aligned counting, 1 = center-aligned counting.
REQ-010 ch_enable  input  CHANNELS  per-channel output enable.
REQ-011 pwm  output  CHANNELS  registered PWM outputs.
REQ-012 period_start  output  1  registered one-cycle pulse marking the first cycle of each period.

Function
REQ-013 The block SHALL use one shared counter, compared against a per-channel active duty.
REQ-014 Effective divider D SHALL be max(div_value, 1).
  - div_value = 0 behaves as 1.
  - With D = 1 the counter holds at 0.
REQ-015 Edge mode SHALL count 0..D-1, then wrap to 0.
  - Period length is D cycles.
REQ-016 Center mode SHALL count up 0..D-1, then down D-2..0, then repeat.
  - Period length is 2*(D-1) cycles for D >= 2.
  - Direction is held in a 1-bit up/down state: UP, DOWN.
REQ-017 Period boundary SHALL be the cycle in which the counter is 0 and the direction is UP.
REQ-018 center_mode and D SHALL be sampled only at a period boundary.
  - Mid-period changes take effect from the next period.
REQ-019 Each channel SHALL hold two registers:
  - working duty W, updated by the adjust strobes;
  - active duty A, used for the compare.
REQ-020 At each period boundary, A SHALL load the value W held before that cycle's adjust (shadowed, glitch-free update).
REQ-021 Adjust priority per channel SHALL be inc_coarse > inc_fine > dec_coarse > dec_fine.
  - One adjust per cycle; lower-priority strobes that cycle are ignored.
REQ-022 Adjust arithmetic SHALL use WIDTH+1 bits and saturate.
  - Increment clamps at D; decrement clamps at 0.
  - No wrap-around.
REQ-023 pwm[ch] SHALL be registered as ch_enable[ch] AND (counter < A[ch]).
  - 1-cycle latency from counter to output.
  - A = 0 gives constant low; A >= D gives constant high.
REQ-024 period_start SHALL be registered with the same 1-cycle latency, so it aligns with the first pwm cycle of the period.
REQ-025 Deasserting ch_enable[ch] SHALL force pwm[ch] low on the next cycle.
  - W and A keep updating.
REQ-026 If the adjust set lowers D below an existing W, W SHALL not be modified.
  - The compare rule in REQ-023 yields constant high.

Reset
REQ-027 When srst_n = 0 at a clock edge, the block SHALL set:
  - counter = 0, direction = UP;
  - every W and A = duty_nominal;
  - pwm = 0, period_start = 0;
  - latched mode and D sampled from the current inputs.
REQ-028 A reset asserted mid-period SHALL abort the period immediately.
  - The first cycle after release is a period boundary.
  - period_start = 1 on the second cycle after release.
REQ-029 Adjust strobes SHALL be ignored while srst_n = 0.

Verification
REQ-030 WIDTH=8, CHANNELS=2, div=10, nominal=3, edge mode, enables=11 -> each pwm high 3 of every 10 cycles; period_start every 10 cycles, coincident with the pwm rising edge.
REQ-031 Channel 0 W=8, inc_coarse with coarse=5, div=10 -> W=10, pwm[0] constant high from the next period; channel 1 W=2, dec_coarse with coarse=5 -> constant low; no wrap.
REQ-032 inc_fine (fine=1) pulsed mid-period, and also on a boundary cycle -> duty changes only at the following period boundary; boundary-cycle adjust delayed one full period.
REQ-033 Center mode, div=5, duty=2 -> counter 0,1,2,3,4,3,2,1 repeating (period 8); pwm high 3 of 8 cycles, symmetric about counter 0; period_start every 8 cycles.
REQ-034 Mode switched edge->center mid-period, then srst_n pulsed low mid-period -> mode switch at next boundary only; after reset all W=A=nominal, pwm=0, counting restarts at 0.
REQ-035 Simultaneous inc_coarse and dec_fine on one channel, plus ch_enable[1]=0 -> only coarse increment applied; pwm[1] low while its W still tracks strobes.

Source files
------------

// File: rtl/multi_pwm_generator.sv
// Multi-channel PWM generator.
// One shared counter (edge- or center-aligned) is compared against a per-channel
// active duty. Each channel keeps a working duty, adjusted by saturating strobes,
// and an active duty that is refreshed from the working duty only at period
// boundaries. This keeps every output glitch-free within a period.
module multi_pwm_generator #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                srst_n,
    input  logic [CHANNELS-1:0] duty_inc_coarse,
    input  logic [CHANNELS-1:0] duty_inc_fine,
    input  logic [CHANNELS-1:0] duty_dec_coarse,
    input  logic [CHANNELS-1:0] duty_dec_fine,
    input  logic [WIDTH-1:0]    duty_coarse,
    input  logic [WIDTH-1:0]    duty_fine,
    input  logic [WIDTH-1:0]    duty_nominal,
    input  logic [WIDTH-1:0]    div_value,
    input  logic                center_mode,
    input  logic [CHANNELS-1:0] ch_enable,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    localparam logic             DIR_UP   = 1'b0;
    localparam logic             DIR_DOWN = 1'b1;
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(2'd1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2'd2);

    // Saturating increment. A working duty already at or above the divider
    // (the divider was lowered under it) is left untouched.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] w,
                                                 input logic [WIDTH-1:0] step,
                                                 input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sum;
        sum = {1'b0, w} + {1'b0, step};
        if (w >= d) begin
            return w;
        end else if (sum > {1'b0, d}) begin
            return d;
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    // Saturating decrement, clamps at zero.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] w,
                                                 input logic [WIDTH-1:0] step);
        logic [WIDTH:0] diff;
        diff = {1'b0, w} - {1'b0, step};
        if (diff[WIDTH]) begin
            return ZERO;
        end else begin
            return diff[WIDTH-1:0];
        end
    endfunction

    logic [WIDTH-1:0]    r_cnt;
    logic                r_dir;
    logic                r_mode;
    logic [WIDTH-1:0]    r_div;
    logic [WIDTH-1:0]    r_w [CHANNELS];
    logic [WIDTH-1:0]    r_a [CHANNELS];
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;

    logic [WIDTH-1:0]    w_div_in;
    logic                w_boundary;
    logic                w_mode_eff;
    logic [WIDTH-1:0]    w_div_eff;
    logic [WIDTH-1:0]    w_div_m1;
    logic [WIDTH-1:0]    w_div_m2;
    logic [WIDTH-1:0]    w_cnt_nxt;
    logic                w_dir_nxt;
    logic [WIDTH-1:0]    w_w_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_cmp;

    // Divider of zero behaves as one. Mode and divider take new values only on
    // the boundary cycle, so the new period starts with its own settings.
    assign w_div_in   = (div_value == ZERO) ? ONE : div_value;
    assign w_boundary = (r_cnt == ZERO) && (r_dir == DIR_UP);
    assign w_mode_eff = w_boundary ? center_mode : r_mode;
    assign w_div_eff  = w_boundary ? w_div_in : r_div;
    assign w_div_m1   = w_div_eff - ONE;
    assign w_div_m2   = w_div_eff - TWO;

    // Next counter value and direction for edge and center counting.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_div_eff == ONE) begin
            w_cnt_nxt = ZERO;
            w_dir_nxt = DIR_UP;
        end else if (!w_mode_eff) begin
            w_dir_nxt = DIR_UP;
            if (r_cnt >= w_div_m1) begin
                w_cnt_nxt = ZERO;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else if (r_dir == DIR_UP) begin
            if (r_cnt >= w_div_m1) begin
                // With D = 2 the down leg is empty: go straight back to 0/UP.
                if (w_div_eff == TWO) begin
                    w_cnt_nxt = ZERO;
                    w_dir_nxt = DIR_UP;
                end else begin
                    w_cnt_nxt = w_div_m2;
                    w_dir_nxt = DIR_DOWN;
                end
            end else begin
                w_cnt_nxt = r_cnt + ONE;
                w_dir_nxt = DIR_UP;
            end
        end else begin
            // The final 0 of the down leg is the next period's boundary.
            if (r_cnt <= ONE) begin
                w_cnt_nxt = ZERO;
                w_dir_nxt = DIR_UP;
            end else begin
                w_cnt_nxt = r_cnt - ONE;
                w_dir_nxt = DIR_DOWN;
            end
        end
    end

    // Per-channel prioritized duty adjust and compare against the active duty.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_w_nxt[ch] = r_w[ch];
            if (duty_inc_coarse[ch]) begin
                w_w_nxt[ch] = sat_inc(r_w[ch], duty_coarse, w_div_eff);
            end else if (duty_inc_fine[ch]) begin
                w_w_nxt[ch] = sat_inc(r_w[ch], duty_fine, w_div_eff);
            end else if (duty_dec_coarse[ch]) begin
                w_w_nxt[ch] = sat_dec(r_w[ch], duty_coarse);
            end else if (duty_dec_fine[ch]) begin
                w_w_nxt[ch] = sat_dec(r_w[ch], duty_fine);
            end else begin
                w_w_nxt[ch] = r_w[ch];
            end
            // On the boundary the freshly shadowed duty already governs cycle 0.
            if (w_boundary) begin
                w_cmp[ch] = ch_enable[ch] && (r_cnt < r_w[ch]);
            end else begin
                w_cmp[ch] = ch_enable[ch] && (r_cnt < r_a[ch]);
            end
        end
    end

    // Counter, latched settings, duty registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_cnt          <= ZERO;
            r_dir          <= DIR_UP;
            r_mode         <= center_mode;
            r_div          <= w_div_in;
            r_pwm          <= {CHANNELS{1'b0}};
            r_period_start <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_w[ch] <= duty_nominal;
                r_a[ch] <= duty_nominal;
            end
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_dir          <= w_dir_nxt;
            r_mode         <= w_mode_eff;
            r_div          <= w_div_eff;
            r_pwm          <= w_cmp;
            r_period_start <= w_boundary;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_w[ch] <= w_w_nxt[ch];
                if (w_boundary) begin
                    r_a[ch] <= r_w[ch];
                end else begin
                    r_a[ch] <= r_a[ch];
                end
            end
        end
    end

    assign pwm          = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Self-checking bench for multi_pwm_generator (WIDTH=8, CHANNELS=2).
// A period-phase reference model predicts pwm/period_start for every cycle;
// predictions are queued when stimulus is applied and compared after the edge.
module tb_multi_pwm_generator;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;

    logic                clk = 1'b0;
    logic                srst_n;
    logic [CHANNELS-1:0] duty_inc_coarse, duty_inc_fine, duty_dec_coarse, duty_dec_fine;
    logic [WIDTH-1:0]    duty_coarse, duty_fine, duty_nominal, div_value;
    logic                center_mode;
    logic [CHANNELS-1:0] ch_enable;
    logic [CHANNELS-1:0] pwm;
    logic                period_start;

    multi_pwm_generator #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk             (clk),
        .srst_n          (srst_n),
        .duty_inc_coarse (duty_inc_coarse),
        .duty_inc_fine   (duty_inc_fine),
        .duty_dec_coarse (duty_dec_coarse),
        .duty_dec_fine   (duty_dec_fine),
        .duty_coarse     (duty_coarse),
        .duty_fine       (duty_fine),
        .duty_nominal    (duty_nominal),
        .div_value       (div_value),
        .center_mode     (center_mode),
        .ch_enable       (ch_enable),
        .pwm             (pwm),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CHANNELS-1:0] pwm;
        logic                ps;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_phase, m_mode, m_d;
    int m_w[CHANNELS];
    int m_a[CHANNELS];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int adj_inc(input int w, input int step, input int d);
        int s;
        s = w + step;
        if (w >= d) return w;
        if (s > d) return d;
        return s;
    endfunction

    function automatic int adj_dec(input int w, input int step);
        if (w < step) return 0;
        return w - step;
    endfunction

    // Predict the outputs visible after the coming clock edge.
    task automatic model_step();
        exp_t e;
        int   cnt, len;
        bit   bnd;
        if (!srst_n) begin
            m_phase = 0;
            m_mode  = int'(center_mode);
            m_d     = (div_value == 8'd0) ? 1 : int'(div_value);
            for (int c = 0; c < CHANNELS; c++) begin
                m_w[c] = int'(duty_nominal);
                m_a[c] = int'(duty_nominal);
            end
            e.pwm = '0;
            e.ps  = 1'b0;
        end else begin
            bnd = (m_phase == 0);
            if (bnd) begin
                m_mode = int'(center_mode);
                m_d    = (div_value == 8'd0) ? 1 : int'(div_value);
                for (int c = 0; c < CHANNELS; c++) m_a[c] = m_w[c];
            end
            cnt = (m_mode != 0 && m_phase >= m_d) ? 2 * (m_d - 1) - m_phase : m_phase;
            for (int c = 0; c < CHANNELS; c++) begin
                e.pwm[c] = ch_enable[c] && (cnt < m_a[c]);
                if (duty_inc_coarse[c])      m_w[c] = adj_inc(m_w[c], int'(duty_coarse), m_d);
                else if (duty_inc_fine[c])   m_w[c] = adj_inc(m_w[c], int'(duty_fine), m_d);
                else if (duty_dec_coarse[c]) m_w[c] = adj_dec(m_w[c], int'(duty_coarse));
                else if (duty_dec_fine[c])   m_w[c] = adj_dec(m_w[c], int'(duty_fine));
            end
            e.ps = bnd;
            len  = (m_mode != 0) ? ((m_d >= 2) ? 2 * (m_d - 1) : 1) : m_d;
            m_phase++;
            if (m_phase >= len) m_phase = 0;
        end
        q.push_back(e);
    endtask

    // One clock: predict, clock, then compare against the scoreboard.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("pwm", int'(pwm), int'(e.pwm));
        check("period_start", int'(period_start), int'(e.ps));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic window(input int n, output int h0, output int h1, output int ps);
        h0 = 0; h1 = 0; ps = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            ps += int'(period_start);
        end
    endtask

    task automatic pulse(input logic [1:0] ic, input logic [1:0] ifn,
                         input logic [1:0] dc, input logic [1:0] df);
        duty_inc_coarse = ic; duty_inc_fine = ifn;
        duty_dec_coarse = dc; duty_dec_fine = df;
        cycle();
        duty_inc_coarse = '0; duty_inc_fine = '0;
        duty_dec_coarse = '0; duty_dec_fine = '0;
    endtask

    task automatic do_reset(input logic [7:0] nominal);
        duty_nominal = nominal;
        srst_n = 1'b0;
        run(2);
        check("reset_pwm", int'(pwm), 0);
        check("reset_ps", int'(period_start), 0);
        srst_n = 1'b1;
        cycle();
        check("ps_after_release", int'(period_start), 1);
    endtask

    initial begin
        int h0, h1, ps, guard;
        srst_n = 1'b0;
        duty_inc_coarse = '0; duty_inc_fine = '0;
        duty_dec_coarse = '0; duty_dec_fine = '0;
        duty_coarse = 8'd5; duty_fine = 8'd1; duty_nominal = 8'd3;
        div_value = 8'd10; center_mode = 1'b0; ch_enable = 2'b11;

        // edge mode, div 10, nominal 3
        do_reset(8'd3);
        window(20, h0, h1, ps);
        check("edge_h0", h0, 6);
        check("edge_h1", h1, 6);
        check("edge_ps", ps, 2);

        // saturation: ch0 3->8->10 (clamp), ch1 3->2->0 (clamp)
        run(3);
        pulse(2'b01, 2'b00, 2'b00, 2'b10);
        pulse(2'b01, 2'b00, 2'b10, 2'b00);
        run(12);
        window(10, h0, h1, ps);
        check("sat_high_h0", h0, 10);
        check("sat_low_h1", h1, 0);

        // shadowed update: mid-period and boundary-cycle fine increments
        do_reset(8'd3);
        run(4);
        pulse(2'b00, 2'b01, 2'b00, 2'b00);
        guard = 0;
        while (m_phase != 0 && guard < 40) begin
            cycle();
            guard++;
        end
        check("boundary_reached", int'(m_phase == 0), 1);
        pulse(2'b00, 2'b11, 2'b00, 2'b00);
        run(25);

        // center mode, div 5, duty 2
        center_mode = 1'b1; div_value = 8'd5;
        do_reset(8'd2);
        window(16, h0, h1, ps);
        check("center_h0", h0, 6);
        check("center_ps", ps, 2);

        // mode switch mid-period, then reset mid-period
        center_mode = 1'b0; div_value = 8'd10;
        do_reset(8'd3);
        run(4);
        center_mode = 1'b1;
        run(23);
        pulse(2'b01, 2'b00, 2'b00, 2'b00);
        run(3);
        center_mode = 1'b0;
        do_reset(8'd3);
        run(20);

        // simultaneous inc_coarse + dec_fine, channel 1 disabled
        ch_enable = 2'b01;
        pulse(2'b11, 2'b00, 2'b00, 2'b11);
        run(12);
        window(10, h0, h1, ps);
        check("disabled_h1", h1, 0);
        check("both_h0", h0, 8);
        ch_enable = 2'b11;
        run(12);

        // divider 0 behaves as 1: counter held at 0
        div_value = 8'd0;
        run(12);
        window(5, h0, h1, ps);
        check("div0_ps", ps, 5);
        check("div0_h0", h0, 5);

        // randomized strobes, divider, mode and enables
        for (int i = 0; i < 120; i++) begin
            duty_inc_coarse = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            duty_inc_fine   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            duty_dec_coarse = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            duty_dec_fine   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 15) == 0) div_value = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 23) == 0) center_mode = ~center_mode;
            if ($urandom_range(0, 15) == 0) ch_enable = 2'($urandom);
            if ($urandom_range(0, 59) == 0) srst_n = 1'b0;
            else srst_n = 1'b1;
            cycle();
        end
        duty_inc_coarse = '0; duty_inc_fine = '0;
        duty_dec_coarse = '0; duty_dec_fine = '0;
        srst_n = 1'b1;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
